// File: rtl/cell_fetch.sv
// Heap cell fetcher: reads a cell header, then its body words, and presents the decoded cell.
// Optional macro CELL_FETCH_BOUNDS_CHECK_EN turns an address wrap past the top of the heap into an error.
module cell_fetch #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_type,
    output logic [DATA_W-1:0] rsp_value,
    output logic [ADDR_W-1:0] rsp_car,
    output logic [ADDR_W-1:0] rsp_cdr,
    output logic              rsp_is_nil,
    output logic              rsp_error
);

    typedef enum logic [1:0] {IDLE, RD_HDR, RD_BODY, DONE} state_t;

    localparam logic [DATA_W-1:0] HDR_NUMBER = DATA_W'(0);
    localparam logic [DATA_W-1:0] HDR_CONS   = DATA_W'(1);
    localparam logic [DATA_W-1:0] HDR_PRIM   = DATA_W'(2);
    localparam logic [DATA_W-1:0] PRIM_MAX   = DATA_W'(2);

    state_t            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] hdr_q;
    logic [DATA_W-1:0] hi_q;
    logic [2:0]        cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_type_q;
    logic [DATA_W-1:0] rsp_value_q;
    logic [ADDR_W-1:0] rsp_car_q;
    logic [ADDR_W-1:0] rsp_cdr_q;
    logic              rsp_is_nil_q;
    logic              rsp_error_q;

    logic [DATA_W-1:0] hdr;
    logic [2:0]        n_body;
    logic              bounds_err;
    logic              abort;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    // The header is only on mem_rdata in the first RD_BODY cycle; afterwards use the latched copy.
    assign hdr = (cnt_q == 3'd0) ? mem_rdata : hdr_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        n_body = 3'd0;
        case (hdr)
            HDR_NUMBER, HDR_PRIM: n_body = 3'd1;
            HDR_CONS:             n_body = 3'd4;
            default:              n_body = 3'd0;
        endcase
    end

`ifdef CELL_FETCH_BOUNDS_CHECK_EN
    logic [ADDR_W:0] last_byte;
    assign last_byte  = {1'b0, base_q} + (ADDR_W+1)'(n_body);
    assign bounds_err = (cnt_q == 3'd0) && last_byte[ADDR_W];
`else
    assign bounds_err = 1'b0;
`endif

    assign abort = (state_q == RD_BODY) && (cnt_q == 3'd0) && ((n_body == 3'd0) || bounds_err);

    // Body reads are issued in the same cycle the header arrives, so the strobe is decoded live.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = mem_addr_q;
        case (state_q)
            RD_HDR: begin
                rd_en   = 1'b1;
                rd_addr = base_q;
            end
            RD_BODY: begin
                if (!abort && (cnt_q < n_body)) begin
                    rd_en   = 1'b1;
                    rd_addr = base_q + ADDR_W'({1'b0, cnt_q} + 4'd1);
                end
            end
            default: ;
        endcase
    end

    assign mem_rd_en  = rd_en;
    assign mem_addr   = rd_addr;
    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_type   = rsp_type_q;
    assign rsp_value  = rsp_value_q;
    assign rsp_car    = rsp_car_q;
    assign rsp_cdr    = rsp_cdr_q;
    assign rsp_is_nil = rsp_is_nil_q;
    assign rsp_error  = rsp_error_q;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            mem_addr_q   <= '0;
            hdr_q        <= '0;
            hi_q         <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_type_q   <= '0;
            rsp_value_q  <= '0;
            rsp_car_q    <= '0;
            rsp_cdr_q    <= '0;
            rsp_is_nil_q <= 1'b0;
            rsp_error_q  <= 1'b0;
        end else begin
            mem_addr_q <= rd_addr;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        base_q       <= req_addr;
                        req_ready_q  <= 1'b0;
                        rsp_type_q   <= '0;
                        rsp_value_q  <= '0;
                        rsp_car_q    <= '0;
                        rsp_cdr_q    <= '0;
                        rsp_error_q  <= 1'b0;
                        if (req_addr == '0) begin
                            rsp_is_nil_q <= 1'b1;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            rsp_is_nil_q <= 1'b0;
                            state_q      <= RD_HDR;
                        end
                    end
                end
                RD_HDR: begin
                    cnt_q   <= 3'd0;
                    state_q <= RD_BODY;
                end
                RD_BODY: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd0) begin
                        hdr_q      <= mem_rdata;
                        rsp_type_q <= mem_rdata;
                    end else if (hdr_q == HDR_CONS) begin
                        case (cnt_q)
                            3'd1, 3'd3: hi_q      <= mem_rdata;
                            3'd2:       rsp_car_q <= ADDR_W'({hi_q, mem_rdata});
                            3'd4:       rsp_cdr_q <= ADDR_W'({hi_q, mem_rdata});
                            default: ;
                        endcase
                    end else begin
                        rsp_value_q <= mem_rdata;
                        if ((hdr_q == HDR_PRIM) && (mem_rdata > PRIM_MAX)) begin
                            rsp_error_q <= 1'b1;
                        end
                    end
                    if (abort || ((cnt_q != 3'd0) && (cnt_q == n_body))) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                        if (abort) begin
                            rsp_error_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
